qeciphy_clk_rst_seq: RTL

//  Sequencer for the PHY clocking MMCM, on the free-running clock domain.
//  - Drives the MMCM reset input.
//  - Watches the MMCM input_clk_stopped output, which arrives asynchronously.
//  - Releases clk_ready only after the MMCM clock has stayed present for a stability window.
//  - Retries automatically on timeout or clock loss. clk_ready gates downstream PHY resets.

---
 rtl/qeciphy_clk_rst_seq_pkg.sv | 20 ++
 rtl/qeciphy_sync_ff.sv | 29 ++
 rtl/qeciphy_clk_rst_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/qeciphy_clk_rst_seq_pkg.sv
// Shared types and constants for the PHY clocking MMCM reset sequencer.
// Statistics outputs are enabled by defining QECIPHY_CLK_RST_SEQ_STATS_EN.
package qeciphy_clk_rst_seq_pkg;

    typedef enum logic [1:0] {
        S_MMCM_RST = 2'd0,
        S_WAIT_CLK = 2'd1,
        S_STABLE   = 2'd2,
        S_READY    = 2'd3
    } seq_state_t;

    localparam int RETRY_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qeciphy_sync_ff.sv
// Multi-stage single-bit synchroniser with a synchronous, active-low reset to RESET_VAL.
module qeciphy_sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/qeciphy_clk_rst_seq.sv
// MMCM reset/clock-stability sequencer on the free-running clock domain.
// Define QECIPHY_CLK_RST_SEQ_STATS_EN to build the retry statistics counters.
module qeciphy_clk_rst_seq
    import qeciphy_clk_rst_seq_pkg::*;
#(
    parameter int MMCM_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES       = 1024,
    parameter int SYNC_STAGES         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_stopped_i,
    input  logic               sw_reset_req,
    output logic               mmcm_reset,
    output logic               clk_ready,
    output logic [1:0]         seq_state,
    output logic [RETRY_W-1:0] retry_count,
    output logic               retry_overflow
);

    localparam int CNT_W = $clog2(max3(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mmcm_reset_q, mmcm_reset_d;
    logic             clk_ready_q, clk_ready_d;
    logic             stopped_s;

    // Resets to "stopped" so nothing is trusted until the MMCM flag has propagated.
    qeciphy_sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_stopped (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk_stopped_i),
        .q     (stopped_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MMCM_RST: if (cnt_q == RST_LAST) state_d = S_WAIT_CLK;
            S_WAIT_CLK: begin
                if (!stopped_s)              state_d = S_STABLE;
                else if (cnt_q == LOCK_LAST) state_d = S_MMCM_RST;
            end
            S_STABLE: begin
                if (stopped_s)                 state_d = S_MMCM_RST;
                else if (cnt_q == STABLE_LAST) state_d = S_READY;
            end
            S_READY:  if (stopped_s) state_d = S_MMCM_RST;
            default:  state_d = S_MMCM_RST;
        endcase
        if (sw_reset_req) state_d = S_MMCM_RST;

        // A software request also restarts an in-progress reset pulse.
        cnt_d = cnt_q;
        if ((state_d != state_q) || sw_reset_req) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        mmcm_reset_d = (state_d == S_MMCM_RST);
        clk_ready_d  = (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_MMCM_RST;
            cnt_q        <= '0;
            mmcm_reset_q <= 1'b1;
            clk_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mmcm_reset_q <= mmcm_reset_d;
            clk_ready_q  <= clk_ready_d;
        end
    end

    assign mmcm_reset = mmcm_reset_q;
    assign clk_ready  = clk_ready_q;
    assign seq_state  = state_q;

`ifdef QECIPHY_CLK_RST_SEQ_STATS_EN
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               overflow_q, overflow_d;
    logic               retry_event;

    // Only a transition into S_MMCM_RST counts; sw_reset_req does not clear stats.
    always_comb begin
        retry_event = (state_d == S_MMCM_RST) && (state_q != S_MMCM_RST);
        retry_d     = retry_q;
        overflow_d  = overflow_q;
        if (retry_event) begin
            if (retry_q == '1) overflow_d = 1'b1;
            else               retry_d    = retry_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            retry_q    <= retry_d;
            overflow_q <= overflow_d;
        end
    end

    assign retry_count    = retry_q;
    assign retry_overflow = overflow_q;
`else
    assign retry_count    = '0;
    assign retry_overflow = 1'b0;
`endif

endmodule
